// File: rtl/judge_timing_ctrl.sv
// Rhythm-game hit judge: classifies each note as PERFECT / NORMAL / MISS from the
// tick offset between note arrival and button press, holds the verdict and tracks combo.
module judge_timing_ctrl #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned PERFECT_TK = 30,
    parameter int unsigned NORMAL_TK  = 80,
    parameter int unsigned HOLD_TK    = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_note,
    input  logic       i_btn,
    output logic [1:0] o_judge,
    output logic       o_judge_pulse,
    output logic [7:0] o_combo
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [7:0]  PERF_L    = 8'(PERFECT_TK);
    localparam logic [7:0]  NORM_L    = 8'(NORMAL_TK);
    localparam logic [15:0] HOLD_L    = 16'(HOLD_TK);

    localparam logic [1:0] J_IDLE    = 2'b00;
    localparam logic [1:0] J_MISS    = 2'b01;
    localparam logic [1:0] J_NORMAL  = 2'b10;
    localparam logic [1:0] J_PERFECT = 2'b11;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic        sync1_q, sync2_q, btn_dly_q;
    logic        armed_q, armed_d;
    logic [7:0]  p_age_q, p_age_d;
    logic [7:0]  n_age_q, n_age_d;
    logic [1:0]  judge_q, judge_d;
    logic        pulse_q, pulse_d;
    logic [7:0]  combo_q, combo_d;
    logic [15:0] hold_q, hold_d;
    logic        tick, press;
    logic        verdict_vld;
    logic [1:0]  verdict_code;

    assign tick    = (presc_q == TICK_LAST);
    assign presc_d = tick ? 16'd0 : presc_q + 16'd1;
    // Rising edge of the synchronized button level; a held button yields one press.
    assign press   = sync2_q & ~btn_dly_q;

    always_comb begin
        state_d      = state_q;
        n_age_d      = n_age_q;
        armed_d      = armed_q;
        p_age_d      = p_age_q;
        verdict_vld  = 1'b0;
        verdict_code = J_IDLE;
        if (armed_q && tick) begin
            if (p_age_q == NORM_L) armed_d = 1'b0;
            else                   p_age_d = p_age_q + 8'd1;
        end
        if (state_q == S_WAIT && tick) n_age_d = n_age_q + 8'd1;
        case (state_q)
            S_IDLE: begin
                if (i_note) begin
                    if (press) begin
                        verdict_vld  = 1'b1;
                        verdict_code = J_PERFECT;
                        armed_d      = 1'b0;
                    end else if (armed_q) begin
                        verdict_vld  = 1'b1;
                        verdict_code = (p_age_q <= PERF_L) ? J_PERFECT : J_NORMAL;
                        armed_d      = 1'b0;
                    end else begin
                        state_d = S_WAIT;
                        n_age_d = 8'd0;
                    end
                end else if (press) begin
                    armed_d = 1'b1;
                    p_age_d = 8'd0;
                end
            end
            S_WAIT: begin
                // A press always resolves the pending note; a simultaneous note starts fresh.
                if (press) begin
                    verdict_vld  = 1'b1;
                    verdict_code = (n_age_q <= PERF_L) ? J_PERFECT : J_NORMAL;
                    if (i_note) n_age_d = 8'd0;
                    else        state_d = S_IDLE;
                end else if (i_note) begin
                    verdict_vld  = 1'b1;
                    verdict_code = J_MISS;
                    n_age_d      = 8'd0;
                end else if (tick && n_age_q == NORM_L) begin
                    verdict_vld  = 1'b1;
                    verdict_code = J_MISS;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        judge_d = judge_q;
        combo_d = combo_q;
        hold_d  = hold_q;
        pulse_d = 1'b0;
        if (verdict_vld) begin
            judge_d = verdict_code;
            pulse_d = 1'b1;
            hold_d  = HOLD_L;
            if (verdict_code == J_MISS)  combo_d = 8'd0;
            else if (combo_q != 8'hFF)   combo_d = combo_q + 8'd1;
        end else if (tick && hold_q != 16'd0) begin
            hold_d = hold_q - 16'd1;
            if (hold_q == 16'd1) judge_d = J_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            presc_q   <= 16'd0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            btn_dly_q <= 1'b0;
            armed_q   <= 1'b0;
            p_age_q   <= 8'd0;
            n_age_q   <= 8'd0;
            judge_q   <= J_IDLE;
            pulse_q   <= 1'b0;
            combo_q   <= 8'd0;
            hold_q    <= 16'd0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            sync1_q   <= i_btn;
            sync2_q   <= sync1_q;
            btn_dly_q <= sync2_q;
            armed_q   <= armed_d;
            p_age_q   <= p_age_d;
            n_age_q   <= n_age_d;
            judge_q   <= judge_d;
            pulse_q   <= pulse_d;
            combo_q   <= combo_d;
            hold_q    <= hold_d;
        end
    end

    assign o_judge       = judge_q;
    assign o_judge_pulse = pulse_q;
    assign o_combo       = combo_q;

endmodule

// File: doc/judge_timing_ctrl.md
Name: judge_timing_ctrl

Overview:
Rhythm-game hit judge sitting directly upstream of the 8-digit seven-segment judgement display. Compares the player's button press against the note-arrival pulse from the note scheduler, classifies each note as PERFECT, NORMAL or MISS, and holds the 2-bit verdict code for a fixed display time. Also maintains a saturating combo counter for the score/LED path.

Parameters:
TICK_DIV, 50000, clk cycles per timing tick (1 ms at 50 MHz); range 2..65535
PERFECT_TK, 30, max |offset| in ticks for PERFECT
NORMAL_TK, 80, max |offset| in ticks for NORMAL; must be > PERFECT_TK, < 255
HOLD_TK, 500, ticks a verdict stays on o_judge before returning to IDLE; < 65536

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
i_note  in  1  one-clk pulse, synchronous to clk: note reaches the hit line
i_btn  in  1  debounced button level, asynchronous to clk, active-high
o_judge  out  2  verdict code: 00 IDLE, 01 MISS, 10 NORMAL, 11 PERFECT
o_judge_pulse  out  1  one-clk strobe when a new verdict is loaded
o_combo  out  8  consecutive non-MISS count, saturates at 255

Behaviour:
- Reset (async, active-high): all state cleared; o_judge=00, o_judge_pulse=0, o_combo=0, FSM=IDLE, prescaler/age/hold counters=0, press not armed, synchronizer FFs=0.
- Tick: prescaler counts 0..TICK_DIV-1, tick=1 for one clk when count==TICK_DIV-1, then wraps to 0; free-running, never reset by events.
- Button: i_btn through 2-FF synchronizer plus one delay FF; press = sync_out & ~delayed. Press is effective in the cycle 2 clk edges after i_btn rises; held level generates only one press.
- Early-press tracker: press in IDLE sets armed=1 and p_age=0; p_age increments per tick while armed; armed clears when p_age would exceed NORMAL_TK (stray press, no penalty, no verdict).
- FSM states: IDLE (no pending note), WAIT (note pending, n_age counts ticks since note).
- IDLE + i_note: if armed and p_age<=PERFECT_TK -> PERFECT; else if armed and p_age<=NORMAL_TK -> NORMAL; armed cleared, stay IDLE. If not armed -> WAIT, n_age=0.
- IDLE + i_note + press same cycle -> PERFECT (offset 0), press consumed.
- WAIT + press: n_age<=PERFECT_TK -> PERFECT; else -> NORMAL; go IDLE. Press is consumed, does not arm.
- WAIT, tick with n_age==NORMAL_TK and no press -> MISS, go IDLE.
- WAIT + i_note (no press): pending note judged MISS immediately; stay WAIT, n_age=0 for the new note.
- WAIT + i_note + press same cycle: press resolves pending note per n_age; new note enters WAIT with n_age=0.
- Verdict load: registered on the clk edge after the deciding event; o_judge<=code, o_judge_pulse=1 for exactly that cycle, hold counter reloaded with HOLD_TK. Verdict during active hold overrides and restarts hold.
- Hold: decrements per tick; when it reaches 0, o_judge<=00 on that edge. No pulse on return to IDLE.
- Combo: PERFECT/NORMAL -> +1 saturating at 255; MISS -> 0. Updated on the same edge as o_judge.
- At most one verdict per clk; when two verdicts arise in one cycle (WAIT + i_note + press), the press verdict wins for o_judge and combo.

Test Plan:
(bench: TICK_DIV=4, PERFECT_TK=2, NORMAL_TK=5, HOLD_TK=10)
- Reset mid-WAIT with o_judge=10, combo=7 -> all outputs 0 asynchronously, no pulse after release.
- i_note, then i_btn rise 6 clk later (effective n_age=1) -> o_judge=11, one-clk pulse, combo 0->1; o_judge returns 00 after 10 ticks (40 clk +-4).
- i_btn rise, i_note 16 clk later (p_age=4) -> NORMAL, combo+1; repeat with p_age=6 -> stray press expires, note then times out -> MISS, combo=0.
- i_note, no press -> MISS exactly on the tick where n_age reaches 5, pulse once, combo cleared.
- i_note, second i_note 8 clk later, then press -> first MISS (combo 0), second PERFECT or NORMAL per n_age; two distinct pulses.
- 260 consecutive PERFECT hits -> o_combo saturates at 255; i_btn held high across two notes -> only first press counts, second note MISS.
